// File: rtl/execute_writeback_if.sv
// Decode-to-execute instruction stream and RAM write-request bus.
// "master" is the upstream decoder plus memory arbiter; "slave" is the execute stage.
interface execute_writeback_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
);
  logic [DATA_W+ADDR_W+3:0] complex_data;
  logic                     data_write;
  logic                     pause_DECODE;
  logic                     ram_wr;
  logic                     ram_garant_wr;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_data;

  modport master (
    output complex_data, data_write, ram_garant_wr,
    input  pause_DECODE, ram_wr, ram_addr, ram_data
  );

  modport slave (
    input  complex_data, data_write, ram_garant_wr,
    output pause_DECODE, ram_wr, ram_addr, ram_data
  );
endinterface

// File: rtl/execute_writeback.sv
// Execute/writeback stage: buffers decoded words in a FIFO, runs them against an
// accumulator and issues RAM writes through a request/grant handshake.
module execute_writeback #(
  parameter int DATA_W     = 14,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  execute_writeback_if.slave bus,
  output logic [DATA_W-1:0] acc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy,
  output logic              illegal_op,
  output logic              overflow_err
);
  localparam int WORD_W = DATA_W + ADDR_W + 4;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_WR_REQ = 2'd2;

  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_STORE  = 4'd7;
  localparam logic [3:0] OP_STOREI = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q, zero_d, carry_q, carry_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              overflow_q, overflow_d;

  logic              fifo_full, push, pop;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              zero_upd;

  assign fifo_full  = (count_q == FULL_CNT);
  assign push       = bus.data_write && !fifo_full;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);

  assign opcode     = instr_q[WORD_W-1 -: 4];
  assign instr_addr = instr_q[DATA_W +: ADDR_W];
  assign operand    = instr_q[DATA_W-1:0];

  // The top bit of the extended difference doubles as the borrow.
  assign sum_ext    = {1'b0, acc_q} + {1'b0, operand};
  assign diff_ext   = {1'b0, acc_q} - {1'b0, operand};

  assign zero_upd   = (opcode inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                      OP_XOR, OP_SHL, OP_SHR});

  // Buffer storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.complex_data;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    instr_d    = instr_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    ram_wr_d   = ram_wr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    overflow_d = overflow_q | (bus.data_write && fifo_full);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          instr_d = fifo_mem[rd_ptr_q];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD: begin
            acc_d   = operand;
            carry_d = 1'b0;
          end
          OP_ADD:  {carry_d, acc_d} = sum_ext;
          OP_SUB:  {carry_d, acc_d} = diff_ext;
          OP_AND:  acc_d = acc_q & operand;
          OP_OR:   acc_d = acc_q | operand;
          OP_XOR:  acc_d = acc_q ^ operand;
          OP_SHL:  {carry_d, acc_d} = {acc_q, 1'b0};
          OP_SHR:  {acc_d, carry_d} = {1'b0, acc_q};
          default: ;
        endcase
        if (zero_upd) zero_d = (acc_d == '0);

        if (opcode == OP_STORE || opcode == OP_STOREI) begin
          state_d    = S_WR_REQ;
          ram_wr_d   = 1'b1;
          ram_addr_d = instr_addr;
          ram_data_d = (opcode == OP_STORE) ? acc_q : operand;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        if (bus.ram_garant_wr) begin
          ram_wr_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      instr_q    <= '0;
      acc_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      instr_q    <= instr_d;
      acc_q      <= acc_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.pause_DECODE = fifo_full;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_data     = ram_data_q;
  assign acc              = acc_q;
  assign zero_flag        = zero_q;
  assign carry_flag       = carry_q;
  assign overflow_err     = overflow_q;
  assign busy             = (state_q != S_IDLE) || (count_q != '0);
  assign illegal_op       = (state_q == S_EXEC) && (opcode > OP_SHR);
endmodule

// File: tb/tb_execute_writeback.sv
// Directed plus randomized bench for execute_writeback, checked against an
// instruction-level accumulator model and an expected RAM-write list.
module tb_execute_writeback;
  localparam int DW = 14;
  localparam int AW = 12;
  localparam int MOD = 1 << DW;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] acc;
  logic zero_flag, carry_flag, busy, illegal_op, overflow_err;

  execute_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  execute_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .acc          (acc),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .busy         (busy),
    .illegal_op   (illegal_op),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_acc = 0;
  int m_z = 0;
  int m_c = 0;
  int m_ill = 0;
  int ill_seen = 0;
  logic [AW+DW-1:0] wr_log[$];
  logic [AW+DW-1:0] exp_wr[$];

  function automatic logic [DW+AW+3:0] mk(int op, int addr, int n);
    logic [3:0]    o = op[3:0];
    logic [AW-1:0] a = addr[AW-1:0];
    logic [DW-1:0] d = n[DW-1:0];
    return {o, a, d};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are observed 1ns after each rising edge.
  task automatic step();
    if (bus.ram_wr && bus.ram_garant_wr) wr_log.push_back({bus.ram_addr, bus.ram_data});
    if (illegal_op) ill_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(int op, int addr, int n);
    bus.complex_data = mk(op, addr, n);
    bus.data_write   = 1'b1;
    step();
    bus.data_write   = 1'b0;
  endtask

  // Instruction semantics as plain integer arithmetic on a 14-bit accumulator.
  task automatic model(int op, int addr, int n);
    int s;
    case (op)
      1: begin m_acc = n; m_c = 0; end
      2: begin s = m_acc + n; m_c = (s >= MOD) ? 1 : 0; m_acc = s % MOD; end
      3: begin m_c = (m_acc < n) ? 1 : 0; m_acc = (m_acc - n + MOD) % MOD; end
      4: m_acc = m_acc & n;
      5: m_acc = m_acc | n;
      6: m_acc = m_acc ^ n;
      7: exp_wr.push_back({addr[AW-1:0], m_acc[DW-1:0]});
      8: exp_wr.push_back({addr[AW-1:0], n[DW-1:0]});
      9: begin m_c = (m_acc >= MOD / 2) ? 1 : 0; m_acc = (m_acc * 2) % MOD; end
      10: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
      default: if (op >= 11) m_ill++;
    endcase
    if ((op >= 1 && op <= 6) || op == 9 || op == 10) m_z = (m_acc == 0) ? 1 : 0;
  endtask

  task automatic drain(bit rnd_grant);
    int n = 0;
    while ((busy || bus.ram_wr) && n < 300) begin
      if (rnd_grant) bus.ram_garant_wr = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.ram_garant_wr = 1'b0;
    chk("drain_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic run(int op, int addr, int n);
    push(op, addr, n);
    model(op, addr, n);
    bus.ram_garant_wr = 1'b1;
    drain(1'b0);
  endtask

  task automatic chk_state(string tag);
    chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
    chk({tag, "_zero"}, 32'(zero_flag), 32'(m_z));
    chk({tag, "_carry"}, 32'(carry_flag), 32'(m_c));
  endtask

  task automatic chk_writes(string tag);
    chk({tag, "_wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    while (wr_log.size() > 0 && exp_wr.size() > 0)
      chk({tag, "_wr_addr_data"}, 32'(wr_log.pop_front()), 32'(exp_wr.pop_front()));
    wr_log.delete();
    exp_wr.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[6];
    int adr[6];
    int nv[6];
    reset = 1'b1;
    bus.complex_data  = '0;
    bus.data_write    = 1'b0;
    bus.ram_garant_wr = 1'b0;
    step();
    step();
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pause", 32'(bus.pause_DECODE), 32'd0);
    chk("rst_flags", 32'({zero_flag, carry_flag, illegal_op, overflow_err}), 32'd0);
    reset = 1'b0;
    step();

    // Pipeline latency: pushed at edge k, executes at edge k+2.
    push(1, 0, 16'h3FFF);
    chk("lat_k_acc", 32'(acc), 32'd0);
    step();
    chk("lat_k1_acc", 32'(acc), 32'd0);
    chk("lat_k1_busy", 32'(busy), 32'd1);
    step();
    chk("lat_k2_acc", 32'(acc), 32'h3FFF);
    chk("lat_k2_busy", 32'(busy), 32'd0);
    model(1, 0, 16'h3FFF);
    chk_state("load");

    run(2, 0, 1);
    chk_state("add_wrap");
    chk("add_wrap_literal", 32'({acc, carry_flag, zero_flag}), 32'({14'h0000, 1'b1, 1'b1}));
    run(3, 0, 1);
    chk_state("sub_borrow");
    chk("sub_borrow_literal", 32'({acc, carry_flag, zero_flag}), 32'({14'h3FFF, 1'b1, 1'b0}));

    run(1, 0, 16'h2001);
    run(9, 0, 0);
    chk_state("shl");
    chk("shl_literal", 32'({acc, carry_flag}), 32'({14'h0002, 1'b1}));
    run(10, 0, 0);
    chk_state("shr");
    chk("shr_literal", 32'({acc, carry_flag}), 32'({14'h0001, 1'b0}));

    // Illegal opcode: single-cycle pulse, state untouched.
    push(15, 0, 16'h1234);
    model(15, 0, 16'h1234);
    chk("ill_before", 32'(illegal_op), 32'd0);
    step();
    chk("ill_exec", 32'(illegal_op), 32'd1);
    step();
    chk("ill_after", 32'(illegal_op), 32'd0);
    chk_state("ill");

    // STORE with the grant withheld for five cycles.
    run(1, 0, 16'h1234);
    bus.ram_garant_wr = 1'b0;
    push(7, 12'hABC, 0);
    model(7, 12'hABC, 0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("st_wait_req", 32'({bus.ram_wr, bus.ram_addr, bus.ram_data}), 32'({1'b1, 12'hABC, 14'h1234}));
      step();
    end
    bus.ram_garant_wr = 1'b1;
    chk("st_grant_req", 32'({bus.ram_wr, bus.ram_addr, bus.ram_data}), 32'({1'b1, 12'hABC, 14'h1234}));
    step();
    bus.ram_garant_wr = 1'b0;
    chk("st_done_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("st_done_busy", 32'(busy), 32'd0);
    chk_writes("store");

    // Overflow: six back-to-back words behind a stalled STORE.
    ops = '{7, 1, 2, 8, 6, 2};
    adr = '{12'h111, 0, 0, 12'h222, 0, 0};
    nv  = '{0, 5, 3, 16'h77, 16'hF, 1};
    for (int i = 0; i < 6; i++) begin
      bus.complex_data = mk(ops[i], adr[i], nv[i]);
      bus.data_write   = 1'b1;
      step();
      if (i == 3) chk("ovf_pause_at3", 32'(bus.pause_DECODE), 32'd0);
      if (i == 4) chk("ovf_pause_full", 32'(bus.pause_DECODE), 32'd1);
    end
    bus.data_write = 1'b0;
    chk("ovf_err", 32'(overflow_err), 32'd1);
    chk("ovf_pause_hold", 32'(bus.pause_DECODE), 32'd1);
    for (int i = 0; i < 5; i++) model(ops[i], adr[i], nv[i]);
    bus.ram_garant_wr = 1'b1;
    drain(1'b0);
    chk_state("ovf");
    chk_writes("ovf");
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    chk("ovf_pause_clear", 32'(bus.pause_DECODE), 32'd0);

    // Asynchronous reset while a STOREI request is pending.
    push(8, 12'h010, 16'h0055);
    step();
    step();
    chk("rstwr_req", 32'(bus.ram_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstwr_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rstwr_acc", 32'(acc), 32'd0);
    chk("rstwr_busy", 32'(busy), 32'd0);
    chk("rstwr_ovf", 32'(overflow_err), 32'd0);
    step();
    reset = 1'b0;
    step();
    m_acc = 0;
    m_z = 0;
    m_c = 0;
    chk_state("rstwr");
    chk_writes("rstwr");

    // Randomized short bursts with a randomly toggling grant.
    for (int b = 0; b < 40; b++) begin
      int blen = int'($urandom_range(1, 3));
      for (int j = 0; j < blen; j++) begin
        int op = int'($urandom_range(0, 15));
        int ad = int'($urandom_range(0, (1 << AW) - 1));
        int n  = ($urandom_range(0, 3) == 0) ? MOD - 1 : int'($urandom_range(0, MOD - 1));
        bus.ram_garant_wr = 1'($urandom_range(0, 1));
        push(op, ad, n);
        model(op, ad, n);
      end
      drain(1'b1);
      chk_state("rnd");
      chk_writes("rnd");
    end
    chk("illegal_count", 32'(ill_seen), 32'(m_ill));
    chk("rnd_no_ovf", 32'(overflow_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
Third pipeline stage, directly downstream of DECODE. Consumes the packed {opcode, address, operand} words that DECODE emits with its data_write strobe. Buffers them in a small FIFO, executes them against an accumulator, and issues RAM write requests through the memory-arbiter grant handshake. Back-pressures DECODE via pause_DECODE when the buffer is full.

Parameters:
DATA_W, 14, operand/accumulator/RAM data width
ADDR_W, 12, RAM address width
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
complex_data  in  DATA_W+ADDR_W+4  packed word: [MSB:MSB-3]=opcode, next ADDR_W bits=addr, low DATA_W bits=operand
data_write  in  1  complex_data valid; one entry per high cycle
pause_DECODE  out  1  high while FIFO holds FIFO_DEPTH entries
ram_wr  out  1  RAM write request to arbiter
ram_garant_wr  in  1  arbiter grant; write completes on a cycle where ram_wr & ram_garant_wr
ram_addr  out  ADDR_W  write address, stable while ram_wr high
ram_data  out  DATA_W  write data, stable while ram_wr high
acc  out  DATA_W  accumulator
zero_flag  out  1  acc==0 after last ALU op
carry_flag  out  1  carry/borrow/shifted-out bit
busy  out  1  FSM not IDLE or FIFO non-empty
illegal_op  out  1  one-cycle pulse on unsupported opcode
overflow_err  out  1  sticky: push attempted while full

Behaviour:
- Reset (async, immediate): FIFO empty (pointers and count 0); FSM=IDLE; all outputs 0 (ram_wr drops mid-request, no completion); request abandoned.
- FIFO push: data_write high and count<FIFO_DEPTH -> entry stored. If count==FIFO_DEPTH the word is dropped, overflow_err set (cleared only by reset). Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle: count unchanged, both take effect.
- pause_DECODE = (count==FIFO_DEPTH), combinational from registered count.
- FSM states: IDLE, EXEC, WR_REQ.
- IDLE: if FIFO non-empty, pop head into instruction register -> EXEC; else stay.
- EXEC (one cycle): decode opcode, update acc/flags at the closing edge.
  - Opcode 7 or 8 -> WR_REQ.
  - All others -> IDLE.
- WR_REQ: ram_wr=1, ram_addr=instr addr, ram_data=acc (op 7) or operand (op 8), all registered and held constant.
  - On an edge where ram_garant_wr=1: ram_wr cleared -> IDLE.
  - No timeout; waits indefinitely.
- Opcodes (N = DATA_W-bit operand):
  - 0 NOP.
  - 1 LOAD: acc=N, carry=0.
  - 2 ADD: {carry,acc}=acc+N (DATA_W+1-bit sum).
  - 3 SUB: {carry,acc}=acc-N; carry=1 on borrow (acc<N).
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 STORE acc.
  - 8 STOREI operand.
  - 9 SHL: carry=acc[MSB], acc<<1.
  - 10 SHR: carry=acc[0], acc>>1 logical.
  - 11-15: treated as NOP; illegal_op pulses high for the EXEC cycle.
- zero_flag updates on ops 1-6, 9, 10; carry_flag on ops 1, 2, 3, 9, 10. Flags are otherwise held.
- Latency: word pushed at edge k with FSM idle and FIFO empty -> popped at k+1 -> acc/flags valid after edge k+2. Store: ram_wr high from after edge k+2 until the grant edge.
- Throughput: 2 cycles per non-store instruction; 3+wait cycles per store.
- busy = (state!=IDLE) | (count!=0).

Test Plan:
- Reset mid-WR_REQ: issue STOREI addr 0x010 data 0x0055, assert reset while ram_wr=1 with no grant -> ram_wr, acc, count drop to 0 at once; no write.
- LOAD 0x3FFF then ADD 0x0001 -> acc=0x0000, carry=1, zero=1; then SUB 0x0001 -> acc=0x3FFF, carry=1 (borrow), zero=0.
- LOAD 0x1234, STORE addr 0xABC, grant held low 5 cycles then high -> ram_wr high 6 cycles with ram_addr=0xABC, ram_data=0x1234 stable, then low; FSM in IDLE.
- Push 6 words back-to-back while the first is a STORE with grant withheld -> pause_DECODE high once count=4; the 6th word is dropped and overflow_err=1 (sticky); the 4 buffered words execute in order after grant.
- Opcode 0xF -> illegal_op pulse exactly 1 cycle; acc and flags unchanged.
- SHL on 0x2001 -> acc=0x0002, carry=1; SHR -> acc=0x0001, carry=0.
